// File: rtl/if_fetch_unit.sv
// Instruction-fetch unit: issues pc to instruction memory over req/ack, holds the
// result at the IF/ID boundary, and stalls the PC. Optional FETCH_STAT_EN adds a wait-cycle counter.
module if_fetch_unit #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] pc,
    input  logic          stall_in,
    input  logic          flush,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    output logic          stall_PC,
    output logic          if_valid,
    output logic [AW-1:0] if_pc,
    output logic [DW-1:0] if_instr,
    output logic [31:0]   fetch_wait_cnt
);

    localparam int unsigned CW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          rst_q;
    logic          req_q, req_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] if_pc_q, if_pc_d;
    logic [DW-1:0] instr_q, instr_d;
    logic          valid_q, valid_d;
    logic          accept;
    logic          slot_free;
    logic          stall_pc_c;

    // Holds off issue for the first cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_q <= 1'b0;
        end else begin
            rst_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            if_pc_q <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            if_pc_q <= if_pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        if_pc_d    = if_pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        accept     = 1'b0;
        stall_pc_c = 1'b1;
        slot_free  = !valid_q || !stall_in;

        case (state_q)
            IDLE: begin
                if (rst_q && slot_free && !flush) begin
                    addr_d  = pc;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    state_d = IDLE;
                    if (!flush) begin
                        instr_d = imem_rdata;
                        if_pc_d = addr_q;
                        accept  = 1'b1;
                    end
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                // Request stays up until memory answers; the data is discarded
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (valid_q && !stall_in) begin
            valid_d = 1'b0;
        end

        if (!rst_q) begin
            stall_pc_c = 1'b1;
        end else if (flush) begin
            stall_pc_c = 1'b0;
        end else if (state_q == WAIT && imem_ack) begin
            stall_pc_c = 1'b0;
        end

        req_d = (state_d != IDLE);
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign stall_PC  = stall_pc_c;
    assign if_valid  = valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = instr_q;

`ifdef FETCH_STAT_EN
    logic [CW-1:0] wait_cnt_q;

    // Counts cycles spent waiting on memory; wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (req_q && !imem_ack) begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
        end
    end

    assign fetch_wait_cnt = wait_cnt_q;
`else
    assign fetch_wait_cnt = CW'(0);
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed table-driven bench for if_fetch_unit plus hand-written reset sequences.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        stall_in;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall_PC;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] fetch_wait_cnt;

    int errors = 0;
    int checks = 0;

    if_fetch_unit #(.AW(32), .DW(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc            (pc),
        .stall_in      (stall_in),
        .flush         (flush),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall_PC      (stall_PC),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr),
        .fetch_wait_cnt(fetch_wait_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall_in;
        logic        flush;
        logic [31:0] pc;
        logic        ack;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_stall;
        logic        exp_valid;
        logic [31:0] exp_ifpc;
        logic [31:0] exp_instr;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs[NV];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic f, input logic [31:0] p, input logic a,
                                input logic [31:0] rd, input logic er, input logic [31:0] ea,
                                input logic es, input logic ev, input logic [31:0] ep,
                                input logic [31:0] ei);
        vec_t v;
        v.stall_in = s; v.flush = f; v.pc = p; v.ack = a; v.rdata = rd;
        v.exp_req = er; v.exp_addr = ea; v.exp_stall = es; v.exp_valid = ev;
        v.exp_ifpc = ep; v.exp_instr = ei;
        return v;
    endfunction

    logic [31:0] wc;
    logic [31:0] exp_cnt;

    initial begin
        //            stl flu pc          ack rdata         req addr        stl val ifpc        instr
        vecs[0]  = mk(0, 0, 32'h0,   0, 32'h0,        0, 32'h0,   1, 0, 32'h0,   32'h0);
        vecs[1]  = mk(0, 0, 32'h0,   1, 32'h13,       1, 32'h0,   0, 0, 32'h0,   32'h0);
        vecs[2]  = mk(0, 0, 32'h4,   0, 32'h0,        0, 32'h0,   1, 1, 32'h0,   32'h13);
        vecs[3]  = mk(0, 0, 32'h4,   1, 32'hAAAA0001, 1, 32'h4,   0, 0, 32'h0,   32'h13);
        vecs[4]  = mk(1, 0, 32'h8,   0, 32'h0,        0, 32'h4,   1, 1, 32'h4,   32'hAAAA0001);
        vecs[5]  = mk(1, 0, 32'h8,   0, 32'h0,        0, 32'h4,   1, 1, 32'h4,   32'hAAAA0001);
        vecs[6]  = mk(1, 0, 32'h8,   0, 32'h0,        0, 32'h4,   1, 1, 32'h4,   32'hAAAA0001);
        vecs[7]  = mk(1, 0, 32'h8,   0, 32'h0,        0, 32'h4,   1, 1, 32'h4,   32'hAAAA0001);
        vecs[8]  = mk(1, 0, 32'h8,   0, 32'h0,        0, 32'h4,   1, 1, 32'h4,   32'hAAAA0001);
        vecs[9]  = mk(0, 0, 32'h8,   0, 32'h0,        0, 32'h4,   1, 1, 32'h4,   32'hAAAA0001);
        vecs[10] = mk(0, 0, 32'h100, 0, 32'h0,        1, 32'h8,   1, 0, 32'h4,   32'hAAAA0001);
        vecs[11] = mk(0, 0, 32'h100, 1, 32'h11111111, 1, 32'h8,   0, 0, 32'h4,   32'hAAAA0001);
        vecs[12] = mk(0, 0, 32'h40,  0, 32'h0,        0, 32'h8,   1, 1, 32'h8,   32'h11111111);
        vecs[13] = mk(0, 0, 32'h40,  0, 32'h0,        1, 32'h40,  1, 0, 32'h8,   32'h11111111);
        vecs[14] = mk(0, 0, 32'h40,  0, 32'h0,        1, 32'h40,  1, 0, 32'h8,   32'h11111111);
        vecs[15] = mk(0, 0, 32'h40,  0, 32'h0,        1, 32'h40,  1, 0, 32'h8,   32'h11111111);
        vecs[16] = mk(0, 0, 32'h40,  1, 32'h22222222, 1, 32'h40,  0, 0, 32'h8,   32'h11111111);
        vecs[17] = mk(0, 0, 32'h80,  0, 32'h0,        0, 32'h40,  1, 1, 32'h40,  32'h22222222);
        vecs[18] = mk(0, 0, 32'h80,  0, 32'h0,        1, 32'h80,  1, 0, 32'h40,  32'h22222222);
        vecs[19] = mk(0, 1, 32'h200, 0, 32'h0,        1, 32'h80,  0, 0, 32'h40,  32'h22222222);
        vecs[20] = mk(0, 0, 32'h200, 0, 32'h0,        1, 32'h80,  1, 0, 32'h40,  32'h22222222);
        vecs[21] = mk(0, 0, 32'h200, 1, 32'hDEADBEEF, 1, 32'h80,  1, 0, 32'h40,  32'h22222222);
        vecs[22] = mk(0, 0, 32'h200, 0, 32'h0,        0, 32'h80,  1, 0, 32'h40,  32'h22222222);
        vecs[23] = mk(0, 0, 32'h200, 0, 32'h0,        1, 32'h200, 1, 0, 32'h40,  32'h22222222);
        vecs[24] = mk(0, 1, 32'h300, 1, 32'h33333333, 1, 32'h200, 0, 0, 32'h40,  32'h22222222);
        vecs[25] = mk(0, 1, 32'h300, 0, 32'h0,        0, 32'h200, 0, 0, 32'h40,  32'h22222222);
        vecs[26] = mk(0, 0, 32'h300, 0, 32'h0,        0, 32'h200, 1, 0, 32'h40,  32'h22222222);
        vecs[27] = mk(0, 0, 32'h300, 0, 32'h0,        1, 32'h300, 1, 0, 32'h40,  32'h22222222);
        vecs[28] = mk(0, 0, 32'h300, 1, 32'h44444444, 1, 32'h300, 0, 0, 32'h40,  32'h22222222);
        vecs[29] = mk(1, 1, 32'h500, 0, 32'h0,        0, 32'h300, 0, 1, 32'h300, 32'h44444444);
        vecs[30] = mk(1, 0, 32'h500, 0, 32'h0,        0, 32'h300, 1, 0, 32'h300, 32'h44444444);
        vecs[31] = mk(1, 0, 32'h500, 0, 32'h0,        1, 32'h500, 1, 0, 32'h300, 32'h44444444);

        rst_n = 1'b0; pc = '0; stall_in = 1'b0; flush = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
        wc = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_req",   0, 32'(imem_req),  32'h0);
        check("rst_addr",  0, imem_addr,      32'h0);
        check("rst_valid", 0, 32'(if_valid),  32'h0);
        check("rst_ifpc",  0, if_pc,          32'h0);
        check("rst_instr", 0, if_instr,       32'h0);
        check("rst_cnt",   0, fetch_wait_cnt, 32'h0);

        // First cycle after release: no request, PC held
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_req",   0, 32'(imem_req), 32'h0);
        check("rel_stall", 0, 32'(stall_PC), 32'h1);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            stall_in   = vecs[i].stall_in;
            flush      = vecs[i].flush;
            pc         = vecs[i].pc;
            imem_ack   = vecs[i].ack;
            imem_rdata = vecs[i].rdata;
            #1;
`ifdef FETCH_STAT_EN
            exp_cnt = wc;
`else
            exp_cnt = '0;
`endif
            check("req",   i, 32'(imem_req), 32'(vecs[i].exp_req));
            check("addr",  i, imem_addr,     vecs[i].exp_addr);
            check("stall", i, 32'(stall_PC), 32'(vecs[i].exp_stall));
            check("valid", i, 32'(if_valid), 32'(vecs[i].exp_valid));
            check("ifpc",  i, if_pc,         vecs[i].exp_ifpc);
            check("instr", i, if_instr,      vecs[i].exp_instr);
            check("cnt",   i, fetch_wait_cnt, exp_cnt);
            if (vecs[i].exp_req && !vecs[i].ack) wc = wc + 32'd1;
        end

        // Asynchronous reset in the middle of a WAIT
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req",   0, 32'(imem_req),   32'h0);
        check("arst_valid", 0, 32'(if_valid),   32'h0);
        check("arst_addr",  0, imem_addr,       32'h0);
        check("arst_cnt",   0, fetch_wait_cnt,  32'h0);

        @(negedge clk);
        stall_in = 1'b0; flush = 1'b0; imem_ack = 1'b0; pc = 32'h0;
        rst_n = 1'b1;
        #1;
        check("rel2_req",   0, 32'(imem_req), 32'h0);
        check("rel2_stall", 0, 32'(stall_PC), 32'h1);
        @(negedge clk);
        #1;
        check("rel2_req",   1, 32'(imem_req), 32'h0);
        @(negedge clk);
        #1;
        check("rel2_req",   2, 32'(imem_req), 32'h1);
        check("rel2_addr",  2, imem_addr,     32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
